// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter in front of the MMIO decoder main port.
// It runs one transaction at a time, and a watchdog completes any access whose slave stays silent.
module mmio_arbiter #(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M-1:0]      m_req,
  input  logic [NUM_M-1:0]      m_we,
  input  logic [32*NUM_M-1:0]   m_addr,
  input  logic [32*NUM_M-1:0]   m_wdata,
  output logic [32*NUM_M-1:0]   m_rdata,
  output logic [NUM_M-1:0]      m_ack,
  output logic [NUM_M-1:0]      m_err,
  output logic                  s_en,
  output logic                  s_we,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  input  logic [31:0]           s_rdata,
  input  logic                  s_ack,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshake: a master raises m_req and holds it, with its command stable, until the
  // one-cycle m_ack. The decoder receives a one-cycle s_en and may answer with s_ack on any
  // later cycle. Only the first s_ack seen in WAIT completes the access.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic        rr_ptr;
  logic        gnt;
  logic [15:0] cnt;
  logic        sel;
  logic [31:0] ack_data;

  // With a single requester that master wins outright. With two, rr_ptr decides.
  assign sel      = (m_req == 2'b11) ? rr_ptr : m_req[1];
  assign ack_data = s_we ? 32'h0 : s_rdata;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      gnt     <= 1'b0;
      cnt     <= '0;
      m_ack   <= '0;
      m_err   <= '0;
      m_rdata <= '0;
      s_en    <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_req != '0) begin
            gnt     <= sel;
            s_we    <= m_we[sel];
            s_addr  <= sel ? m_addr[63:32]  : m_addr[31:0];
            s_wdata <= sel ? m_wdata[63:32] : m_wdata[31:0];
            s_en    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          s_en  <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // An ack on the limit cycle still counts as success.
          if (s_ack) begin
            m_ack[gnt] <= 1'b1;
            m_err[gnt] <= 1'b0;
            if (gnt) m_rdata[63:32] <= ack_data;
            else     m_rdata[31:0]  <= ack_data;
            state <= DONE;
          end else if (cnt == LIMIT) begin
            m_ack[gnt] <= 1'b1;
            m_err[gnt] <= 1'b1;
            if (gnt) m_rdata[63:32] <= 32'hDEAD_BEEF;
            else     m_rdata[31:0]  <= 32'hDEAD_BEEF;
            state <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          m_ack  <= '0;
          m_err  <= '0;
          rr_ptr <= ~gnt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-timeline model of the arbiter.
module tb_mmio_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [63:0] m_rdata;
  logic [1:0]  m_ack;
  logic [1:0]  m_err;
  logic        s_en;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata = '0;
  logic        s_ack = 1'b0;
  logic        busy;
  logic [1:0]  dbg_state;

  mmio_arbiter #(.NUM_M(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err), .s_en(s_en), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reference model: one transaction described by its start cycle t0 and completion cycle.
  int          cyc = 0;
  int          md_t0 = 0;
  int          md_done = -1;
  bit          md_active = 1'b0;
  bit          md_g = 1'b0;
  bit          md_rr = 1'b0;
  bit          md_err = 1'b0;
  bit          md_swe = 1'b0;
  logic [31:0] md_saddr = '0;
  logic [31:0] md_swdata = '0;
  logic [31:0] md_rdata = '0;
  logic [31:0] md_rd [2] = '{32'h0, 32'h0};
  logic [1:0]  e_ack;
  logic [1:0]  e_err;
  int          n_acks = 0;
  int          n_to = 0;

  task automatic model_reset();
    md_active = 1'b0;
    md_done   = -1;
    md_rr     = 1'b0;
    md_swe    = 1'b0;
    md_saddr  = '0;
    md_swdata = '0;
    md_rd[0]  = '0;
    md_rd[1]  = '0;
  endtask

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      e_ack = 2'b00;
      e_err = 2'b00;
      if (md_active && cyc == md_done) begin
        e_ack[md_g] = 1'b1;
        e_err[md_g] = md_err;
        md_rd[md_g] = md_rdata;
        n_acks++;
      end
      check("m_ack", 64'(m_ack), 64'(e_ack));
      check("m_err", 64'(m_err), 64'(e_err));
      check("m_rdata", m_rdata, {md_rd[1], md_rd[0]});
      check("s_en", 64'(s_en), 64'(md_active && cyc == md_t0 + 1));
      check("s_we", 64'(s_we), 64'(md_swe));
      check("s_addr", 64'(s_addr), 64'(md_saddr));
      check("s_wdata", 64'(s_wdata), 64'(md_swdata));
      check("busy", 64'(busy), 64'(md_active));
      if (rst) begin
        model_reset();
      end else if (md_active) begin
        if (cyc == md_done) begin
          md_active = 1'b0;
          md_rr = ~md_g;
        end else if (md_done < 0 && cyc >= md_t0 + 2) begin
          if (s_ack) begin
            md_done  = cyc + 1;
            md_err   = 1'b0;
            md_rdata = md_swe ? 32'h0 : s_rdata;
          end else if (cyc - (md_t0 + 2) == TO - 1) begin
            md_done  = cyc + 1;
            md_err   = 1'b1;
            md_rdata = 32'hDEAD_BEEF;
            n_to++;
          end
        end
      end else if (m_req != 2'b00) begin
        md_g      = (m_req == 2'b11) ? md_rr : m_req[1];
        md_swe    = m_we[md_g];
        md_saddr  = md_g ? m_addr[63:32] : m_addr[31:0];
        md_swdata = md_g ? m_wdata[63:32] : m_wdata[31:0];
        md_active = 1'b1;
        md_t0     = cyc;
        md_done   = -1;
      end
    end
  end

  // Scoreboard for grant order under contention
  logic [0:0] exp_q[$];

  bit [4:0] dly;
  bit       armed;
  int       got;

  initial begin
    // Reset
    rst = 1'b1;
    tick_n(2);
    chk_en = 1'b1;
    check("rst_m_ack", 64'(m_ack), 64'h0);
    check("rst_m_rdata", m_rdata, 64'h0);
    check("rst_s_en", 64'(s_en), 64'h0);
    check("rst_s_addr", 64'(s_addr), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    tick();

    // Single CPU read: slave answers two cycles after s_en
    m_req = 2'b01; m_we = 2'b00; m_addr[31:0] = 32'h0600_0010;
    tick();
    check("cpu_rd_s_en", 64'(s_en), 64'h1);
    check("cpu_rd_s_addr", 64'(s_addr), 64'h0600_0010);
    tick();
    tick();
    s_ack = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    s_ack = 1'b0; s_rdata = 32'h0;
    check("cpu_rd_ack", 64'(m_ack), 64'h1);
    check("cpu_rd_data", 64'(m_rdata[31:0]), 64'h1234_5678);
    check("cpu_rd_err", 64'(m_err), 64'h0);
    m_req = 2'b00;
    tick();

    // DMA write: immediate ack
    m_req = 2'b10; m_we = 2'b10; m_addr[63:32] = 32'h0900_0004; m_wdata[63:32] = 32'hA5A5_0001;
    tick();
    check("dma_wr_s_en", 64'(s_en), 64'h1);
    check("dma_wr_s_we", 64'(s_we), 64'h1);
    check("dma_wr_s_wdata", 64'(s_wdata), 64'hA5A5_0001);
    tick();
    s_ack = 1'b1; s_rdata = 32'hFFFF_0000;
    tick();
    s_ack = 1'b0;
    check("dma_wr_ack", 64'(m_ack), 64'h2);
    check("dma_wr_rdata", 64'(m_rdata[63:32]), 64'h0);
    m_req = 2'b00; m_we = 2'b00;
    tick();

    // Timeout, followed by a late ack that must be discarded
    m_req = 2'b01; m_addr[31:0] = 32'h0700_0000;
    tick_n(9);
    check("to_no_early_ack", 64'(m_ack), 64'h0);
    tick();
    check("to_ack", 64'(m_ack), 64'h1);
    check("to_err", 64'(m_err), 64'h1);
    check("to_rdata", 64'(m_rdata[31:0]), 64'hDEAD_BEEF);
    m_req = 2'b00;
    tick_n(2);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("late_ack_ignored", 64'(m_ack), 64'h0);
    check("late_ack_idle", 64'(busy), 64'h0);
    tick();
    check("late_ack_ignored2", 64'(m_ack), 64'h0);

    // Ack on the cycle the counter reaches its limit
    m_req = 2'b01; m_addr[31:0] = 32'h0600_0020;
    tick_n(9);
    s_ack = 1'b1; s_rdata = 32'h0BAD_F00D;
    check("limit_no_early_ack", 64'(m_ack), 64'h0);
    tick();
    s_ack = 1'b0;
    check("limit_ack", 64'(m_ack), 64'h1);
    check("limit_err", 64'(m_err), 64'h0);
    check("limit_rdata", 64'(m_rdata[31:0]), 64'h0BAD_F00D);
    m_req = 2'b00;
    tick();

    // Contention from reset with an always-ready slave
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_req = 2'b11; m_we = 2'b00; m_addr = {32'h0200_0000, 32'h0100_0000};
    s_ack = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(1'(k % 2));
    got = 0;
    for (int k = 0; k < 60 && got < 8; k++) begin
      tick();
      if (m_ack != 2'b00) begin
        check("contention_grant", 64'(m_ack), (exp_q.pop_front() == 1'b1) ? 64'h2 : 64'h1);
        got++;
        if (got == 8) m_req = 2'b00;
      end
    end
    check("contention_count", 64'(got), 64'd8);
    s_ack = 1'b0;
    tick();

    // Reset while a DMA access sits in WAIT
    m_req = 2'b10; m_addr[63:32] = 32'h0900_0100;
    tick_n(2);
    rst = 1'b1; m_req = 2'b00;
    tick();
    rst = 1'b0;
    check("rstw_busy", 64'(busy), 64'h0);
    check("rstw_m_ack", 64'(m_ack), 64'h0);
    check("rstw_m_rdata", m_rdata, 64'h0);
    check("rstw_s_en", 64'(s_en), 64'h0);
    check("rstw_s_addr", 64'(s_addr), 64'h0);
    tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("rstw_stray_ack", 64'(m_ack), 64'h0);
    m_req = 2'b11; m_addr = {32'h0200_0000, 32'h0100_0000};
    tick();
    check("rstw_cpu_first", 64'(s_addr), 64'h0100_0000);
    tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("rstw_cpu_ack", 64'(m_ack), 64'h1);
    m_req[0] = 1'b0;
    tick_n(3);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("rstw_dma_ack", 64'(m_ack), 64'h2);
    m_req = 2'b00;
    tick();

    // Random traffic
    armed = 1'b0;
    dly = '0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        m_req = 2'b00;
        armed = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m_ack[i]) begin
            m_req[i] = 1'b0;
          end else if (!m_req[i] && $urandom_range(0, 2) == 0) begin
            m_req[i] = 1'b1;
            m_we[i] = 1'($urandom_range(0, 1));
            m_addr[i*32 +: 32] = $urandom();
            m_wdata[i*32 +: 32] = $urandom();
          end
        end
      end
      s_rdata = $urandom();
      if (s_en) begin
        armed = 1'b1;
        dly = 5'($urandom_range(0, 10));
        s_ack = 1'b0;
      end else if (armed) begin
        if (dly == 0) begin
          s_ack = 1'b1;
          armed = 1'b0;
        end else begin
          dly = dly - 5'd1;
          s_ack = 1'b0;
        end
      end else begin
        s_ack = ($urandom_range(0, 7) == 0);
      end
    end
    rst = 1'b0;
    m_req = 2'b00;
    s_ack = 1'b0;
    tick_n(20);
    check("random_acks_seen", 64'(n_acks > 100), 64'h1);
    check("random_timeouts_seen", 64'(n_to > 3), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter in front of the MMIO address decoder. Shares the single MMIO main port between the CPU (master 0) and the DMA engine (master 1). Grants one transaction at a time using round-robin priority, drives one-cycle enables into the decoder, and waits for the selected slave's acknowledge. A watchdog completes any transaction whose slave never answers, so a bad address cannot hang the system bus.

## Interface
Parameters:
- NUM_M, 2, number of masters; 2 is the only supported value.
- TIMEOUT, 255, WAIT-state cycles before a transaction is forced to complete with error (1..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- m_req    in   1*2   per-master request; held high until that master's m_ack
- m_we     in   1*2   per-master write enable; 1 = write, 0 = read
- m_addr   in   32*2  per-master byte address; master i at bits [32*i+31:32*i]
- m_wdata  in   32*2  per-master write data
- m_rdata  out  32*2  per-master read data; valid only in its m_ack cycle
- m_ack    out  1*2   per-master one-cycle completion pulse
- m_err    out  1*2   per-master error flag; valid with m_ack
- s_en     out  1     to decoder main port: one-cycle access strobe
- s_we     out  1     to decoder: write enable
- s_addr   out  32    to decoder: address
- s_wdata  out  32    to decoder: write data
- s_rdata  in   32    from decoder: read data, valid with s_ack
- s_ack    in   1     from decoder: slave completion
- busy     out  1     high in every state except IDLE

## Operation
The block has four states: IDLE, ISSUE, WAIT and DONE.

- **IDLE:**
  - If no m_req is high, stay in IDLE.
  - Otherwise select a grant g. If only one master requests, g is that master. If both request, g = rr_ptr.
  - Latch m_we[g], m_addr[g] and m_wdata[g] into internal registers, then go to ISSUE.
- **ISSUE:** drive s_en = 1 with the latched s_we, s_addr and s_wdata. Clear the timeout counter and go to WAIT.
- **WAIT:**
  - s_en = 0. s_addr, s_we and s_wdata hold their latched values.
  - When s_ack is high: capture s_rdata if the access is a read, or 0 if it is a write. Set err = 0 and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT - 1 without s_ack: rdata = 32'hDEAD_BEEF, err = 1, go to DONE.
- **DONE:**
  - m_ack[g] = 1, m_rdata[g] = captured data, m_err[g] = err.
  - rr_ptr = ~g. The served master becomes lowest priority.
  - Go to IDLE.
- rr_ptr resets to 0, so the CPU wins the first contention.
- m_rdata for a non-granted master holds its last value. m_ack and m_err for a non-granted master are 0.
- s_ack is ignored in IDLE, ISSUE and DONE. A late ack that arrives after a timeout is discarded.
- m_req of the granted master is not re-sampled until IDLE. A master drops m_req in its own ack cycle. If it keeps m_req high past the ack cycle, the arbiter treats that as a new request.
- The arbiter does no address decode. Out-of-range addresses reach the decoder, get no s_ack, and end in a timeout.

## Timing
- **Reset:** state = IDLE, rr_ptr = 0, counter = 0. All outputs are 0: m_ack, m_err, m_rdata, s_en, s_we, s_addr, s_wdata and busy.
- **Reset mid-transaction:** the transaction is abandoned with no m_ack and no s_en. Masters re-issue after reset.
- **Latency** (request first high in IDLE at cycle 0):
  - s_en at cycle 1.
  - Earliest accepted s_ack at cycle 2.
  - m_ack is registered, one cycle after the s_ack cycle. Minimum request-to-ack latency is 3 cycles.
  - Timeout ack arrives at cycle 2 + TIMEOUT.
- **Back-to-back:** IDLE is always occupied for at least one cycle between transactions. Peak throughput is one transaction per 4 cycles.
- **Simultaneous events:**
  - Both requests rising together in IDLE resolve by rr_ptr.
  - A new request from the other master during WAIT or DONE waits for IDLE, then wins because rr_ptr has flipped.
  - s_ack in the same cycle the counter hits its limit counts as success (err = 0).
- **Counter width:** 16 bits. It saturates at TIMEOUT - 1 and never wraps.

## Test plan
- **Single CPU read:** m_req[0] = 1, m_addr[31:0] = 0x0600_0010, m_we = 0. Slave acks 2 cycles after s_en with 0x1234_5678 -> s_en one cycle at cycle 1 with s_addr = 0x0600_0010; m_ack[0] at cycle 4 with m_rdata[31:0] = 0x1234_5678 and m_err[0] = 0.
- **DMA write:** m_req[1] = 1, m_we[1] = 1, addr 0x0900_0004, wdata 0xA5A5_0001. Slave acks at cycle 2 -> s_we = 1 and s_wdata = 0xA5A5_0001 while s_en = 1; m_ack[1] at cycle 3; m_rdata[63:32] = 0.
- **Contention:** both masters request continuously from reset, slave acks immediately. Grants alternate 0, 1, 0, 1. No master is served twice in a row while the other is waiting.
- **Timeout:** read to 0x0700_0000 with no s_ack and TIMEOUT = 8 -> m_ack[0] at cycle 10 with m_err[0] = 1 and m_rdata = 0xDEAD_BEEF. A late s_ack at cycle 12 causes no extra m_ack.
- **Reset in WAIT:** rst = 1 for one cycle during WAIT -> the next cycle shows busy = 0 and all outputs 0. A subsequent s_ack is ignored, and a new request proceeds normally with the CPU favoured.
- **Ack at limit:** s_ack arrives exactly on the cycle the counter reaches TIMEOUT - 1 -> m_err = 0 and m_rdata = s_rdata.
